// File: rtl/sev_seg_scan_ctrl.sv
// Time-multiplexed scanner for a common-anode seven-segment display with frame-coherent inputs.
// Define SEV_SEG_BLINK_EN to blink the open-door glyph every BLINK_DIV cycles.
module sev_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int SEL_W       = $clog2(NUM_DIGITS),
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [SEL_W-1:0]      floor_sel,
  input  logic                  door,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] select,
  output logic                  frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [SEL_W-1:0] IDX_MAX   = SEL_W'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_DARK   = 7'h7F;
  localparam logic [6:0] SEG_OPEN   = 7'b1000011;
  localparam logic [6:0] SEG_CLOSED = 7'b0100011;
  localparam logic [6:0] SEG_DASH   = 7'b0111111;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [SEL_W-1:0]      sh_floor_q, sh_floor_d;
  logic                  sh_door_q, sh_door_d;
  logic [6:0]            segments_q, segments_d;
  logic [NUM_DIGITS-1:0] select_q, select_d;
  logic                  frame_done_q, frame_done_d;
  logic                  blink_off;

  // Shadows track the inputs continuously while disabled so re-enable shows fresh values.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sh_floor_d   = sh_floor_q;
    sh_door_d    = sh_door_q;
    frame_done_d = 1'b0;
    if (!en) begin
      cnt_d      = '0;
      idx_d      = '0;
      sh_floor_d = floor_sel;
      sh_door_d  = door;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d        = '0;
        sh_floor_d   = floor_sel;
        sh_door_d    = door;
        frame_done_d = 1'b1;
      end else begin
        idx_d = idx_q + SEL_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    segments_d = SEG_DARK;
    select_d   = '1;
    if (en && (cnt_q >= CNT_BLANK)) begin
      select_d = ~(NUM_DIGITS'(1) << idx_q);
      if (idx_q == sh_floor_q) begin
        if (sh_door_q) segments_d = blink_off ? SEG_DARK : SEG_OPEN;
        else           segments_d = SEG_CLOSED;
      end else begin
        segments_d = SEG_DASH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_floor_q   <= '0;
      sh_door_q    <= 1'b0;
      segments_q   <= SEG_DARK;
      select_q     <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_floor_q   <= sh_floor_d;
      sh_door_q    <= sh_door_d;
      segments_q   <= segments_d;
      select_q     <= select_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef SEV_SEG_BLINK_EN
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_DIV - 1);

  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BL_W'(1);
    phase_d     = phase_q;
    if (!en) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BL_MAX) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_off = phase_q;
`else
  logic unused_blink;
  assign unused_blink = ^BLINK_DIV;
  assign blink_off    = 1'b0;
`endif

  assign segments   = segments_q;
  assign select     = select_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Self-checking bench for sev_seg_scan_ctrl: directed timing checks plus randomized
// stimulus compared against a slot/frame arithmetic model of the scan.
module tb_sev_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RDIV  = 8;
  localparam int BLANK = 2;
  localparam int BDIV  = 64;
  localparam int FRAME = ND * RDIV;

  localparam logic [6:0] DARK   = 7'h7F;
  localparam logic [6:0] OPEN   = 7'b1000011;
  localparam logic [6:0] CLOSED = 7'b0100011;
  localparam logic [6:0] DASH   = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       door = 1'b0;
  logic [1:0] floor_sel = 2'd0;
  logic [6:0] segments;
  logic [3:0] select;
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: m_t = enabled cycles since the scan (re)started.
  int         m_t = 0;
  int         m_floor = 0;
  logic       m_door = 1'b0;
  logic [6:0] exp_seg;
  logic [3:0] exp_sel;
  logic       exp_fd;

  sev_seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .SEL_W      (2),
    .REFRESH_DIV(RDIV),
    .BLANK_CYC  (BLANK),
    .BLINK_DIV  (BDIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .floor_sel (floor_sel),
    .door      (door),
    .segments  (segments),
    .select    (select),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_t     = 0;
    m_floor = 0;
    m_door  = 1'b0;
  endtask

  // Predicts the outputs after the coming edge from the current inputs, then advances one edge.
  task automatic tick();
    int slot_pos;
    int digit;
    exp_seg = DARK;
    exp_sel = 4'hF;
    exp_fd  = 1'b0;
    if (!en) begin
      m_t     = 0;
      m_floor = int'(floor_sel);
      m_door  = door;
    end else begin
      slot_pos = m_t % RDIV;
      digit    = (m_t / RDIV) % ND;
      if (slot_pos >= BLANK) begin
        exp_sel = ~(4'b0001 << digit);
        if (digit == m_floor) exp_seg = m_door ? OPEN : CLOSED;
        else                  exp_seg = DASH;
      end
      exp_fd = ((m_t % FRAME) == FRAME - 1);
      if (exp_fd) begin
        m_floor = int'(floor_sel);
        m_door  = door;
      end
      m_t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_tests++;
    if (segments !== DARK) begin n_fail++; $display("[TB] FAIL reset_segments: got %b, expected %b", segments, DARK); end
    n_tests++;
    if (select !== 4'hF) begin n_fail++; $display("[TB] FAIL reset_select: got %b, expected %b", select, 4'hF); end
    n_tests++;
    if (frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_done: got %b, expected 0", frame_done); end
    @(posedge clk);
    #1;
    n_tests++;
    if ({select, segments} !== {4'hF, DARK}) begin n_fail++; $display("[TB] FAIL reset_held: sel/seg=%b/%b, expected %b/%b", select, segments, 4'hF, DARK); end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    floor_sel = 2'd0;
    door = 1'b0;
    model_reset();
  endtask

  task automatic test_scan();
    for (int e = 1; e <= 56; e++) begin
      tick();
      n_tests++;
      if (segments !== exp_seg || select !== exp_sel || frame_done !== exp_fd) begin
        n_fail++;
        $display("[TB] FAIL scan_model edge %0d: seg=%b sel=%b fd=%b, expected seg=%b sel=%b fd=%b", e, segments, select, frame_done, exp_seg, exp_sel, exp_fd);
      end
      case (e)
        2:  begin n_tests++; if ({select, segments} !== {4'hF, DARK})      begin n_fail++; $display("[TB] FAIL scan_e2: sel/seg=%b/%b, expected %b/%b", select, segments, 4'hF, DARK); end end
        3:  begin n_tests++; if ({select, segments} !== {4'b1110, CLOSED}) begin n_fail++; $display("[TB] FAIL scan_e3: sel/seg=%b/%b, expected %b/%b", select, segments, 4'b1110, CLOSED); end end
        11: begin n_tests++; if ({select, segments} !== {4'b1101, DASH})   begin n_fail++; $display("[TB] FAIL scan_e11: sel/seg=%b/%b, expected %b/%b", select, segments, 4'b1101, DASH); end end
        19: begin n_tests++; if ({select, segments} !== {4'b1011, DASH})   begin n_fail++; $display("[TB] FAIL scan_e19: sel/seg=%b/%b, expected %b/%b", select, segments, 4'b1011, DASH); end end
        22: begin n_tests++; if ({select, segments} !== {4'b1011, DASH})   begin n_fail++; $display("[TB] FAIL scan_midframe: sel/seg=%b/%b, expected %b/%b", select, segments, 4'b1011, DASH); end end
        27: begin n_tests++; if ({select, segments} !== {4'b0111, DASH})   begin n_fail++; $display("[TB] FAIL scan_e27: sel/seg=%b/%b, expected %b/%b", select, segments, 4'b0111, DASH); end end
        31: begin n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL frame_done_early: got %b, expected 0", frame_done); end end
        32: begin n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("[TB] FAIL frame_done_pulse: got %b, expected 1", frame_done); end end
        33: begin n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL frame_done_width: got %b, expected 0", frame_done); end end
        51: begin n_tests++; if ({select, segments} !== {4'b1011, OPEN})   begin n_fail++; $display("[TB] FAIL scan_frame1_open: sel/seg=%b/%b, expected %b/%b", select, segments, 4'b1011, OPEN); end end
        default: ;
      endcase
      if (e == 20) begin
        floor_sel = 2'd2;
        door = 1'b1;
      end
    end
  endtask

  task automatic test_en_gating();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (segments !== exp_seg || select !== exp_sel || frame_done !== exp_fd) begin n_fail++; $display("[TB] FAIL gate_pre %0d: seg=%b sel=%b fd=%b, expected seg=%b sel=%b fd=%b", i, segments, select, frame_done, exp_seg, exp_sel, exp_fd); end
    end
    en = 1'b0;
    floor_sel = 2'd1;
    door = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({select, segments, frame_done} !== {4'hF, DARK, 1'b0}) begin n_fail++; $display("[TB] FAIL gate_off %0d: sel/seg/fd=%b/%b/%b, expected %b/%b/0", i, select, segments, frame_done, 4'hF, DARK); end
    end
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (segments !== exp_seg || select !== exp_sel || frame_done !== exp_fd) begin n_fail++; $display("[TB] FAIL gate_resume %0d: seg=%b sel=%b fd=%b, expected seg=%b sel=%b fd=%b", i, segments, select, frame_done, exp_seg, exp_sel, exp_fd); end
      if (i == 3) begin
        n_tests++;
        if ({select, segments} !== {4'b1110, DASH}) begin n_fail++; $display("[TB] FAIL gate_resume_digit0: sel/seg=%b/%b, expected %b/%b", select, segments, 4'b1110, DASH); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    en = 1'b0;
    tick();
    en = 1'b1;
    for (int i = 1; i <= 3 * FRAME; i++) begin
      door = 1'($urandom_range(0, 1));
      tick();
      if (frame_done === 1'b1) pulses++;
      n_tests++;
      if (segments !== exp_seg || select !== exp_sel || frame_done !== exp_fd) begin n_fail++; $display("[TB] FAIL b2b_model %0d: seg=%b sel=%b fd=%b, expected seg=%b sel=%b fd=%b", i, segments, select, frame_done, exp_seg, exp_sel, exp_fd); end
    end
    n_tests++;
    if (pulses != 3) begin n_fail++; $display("[TB] FAIL b2b_pulse_count: got %0d, expected 3", pulses); end
  endtask

  task automatic test_async_reset();
    int k;
    k = 0;
    while (exp_sel !== 4'b1011 && k < 100) begin
      tick();
      k++;
      n_tests++;
      if (segments !== exp_seg || select !== exp_sel || frame_done !== exp_fd) begin n_fail++; $display("[TB] FAIL areset_pre %0d: seg=%b sel=%b fd=%b, expected seg=%b sel=%b fd=%b", k, segments, select, frame_done, exp_seg, exp_sel, exp_fd); end
    end
    n_tests++;
    if (k >= 100) begin n_fail++; $display("[TB] FAIL areset_wait: waited %0d cycles, expected digit 2 within 100", k); end
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({select, segments, frame_done} !== {4'hF, DARK, 1'b0}) begin n_fail++; $display("[TB] FAIL areset_immediate: sel/seg/fd=%b/%b/%b, expected %b/%b/0", select, segments, frame_done, 4'hF, DARK); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (segments !== exp_seg || select !== exp_sel || frame_done !== exp_fd) begin n_fail++; $display("[TB] FAIL areset_restart %0d: seg=%b sel=%b fd=%b, expected seg=%b sel=%b fd=%b", i, segments, select, frame_done, exp_seg, exp_sel, exp_fd); end
      if (i == 3) begin
        n_tests++;
        if ({select, segments} !== {4'b1110, CLOSED}) begin n_fail++; $display("[TB] FAIL areset_digit0: sel/seg=%b/%b, expected %b/%b", select, segments, 4'b1110, CLOSED); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      if (en && $urandom_range(0, 149) == 0)        en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0)    en = 1'b1;
      if ($urandom_range(0, 11) == 0) floor_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) door = 1'($urandom_range(0, 1));
      tick();
      n_tests++;
      if (segments !== exp_seg || select !== exp_sel || frame_done !== exp_fd) begin n_fail++; $display("[TB] FAIL random %0d: seg=%b sel=%b fd=%b, expected seg=%b sel=%b fd=%b", i, segments, select, frame_done, exp_seg, exp_sel, exp_fd); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_en_gating();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
